// File: rtl/button_pkg.sv
// button_pkg: definitions shared by the button input path.
//   - CLK_FREQ: project-wide system clock frequency, also used by the buzzer timing.
//   - DEFAULT_DEBOUNCE_CYCLES: 20 ms of stable input at CLK_FREQ.
//   - DEFAULT_LONG_CYCLES: 1 s hold at CLK_FREQ.
//   - btn_state_t: 3-bit encoding of the button FSM states.
package button_pkg;

    localparam int unsigned CLK_FREQ                = 50_000_000;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = CLK_FREQ / 50;
    localparam int unsigned DEFAULT_LONG_CYCLES     = CLK_FREQ;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StDbPress = 3'd1,
        StPressed = 3'd2,
        StHeld    = 3'd3,
        StDbRel   = 3'd4
    } btn_state_t;

endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchronizer for a single asynchronous pin input.
//   clk   - destination clock
//   reset - asynchronous, active-low; both flops load RESET_VALUE
//   d     - raw asynchronous input
//   q     - synchronized output, two clk edges behind d
module sync2 #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_event.sv
// button_event: debounces one active-low push button and emits single-cycle tap/hold events.
//   clk         - system clock
//   reset       - asynchronous, active-low
//   btn_n       - raw button pin, low = pressed, asynchronous to clk
//   pressed     - debounced level, high while a press is accepted
//   short_pulse - one cycle on release of a press that never became a long press
//   long_pulse  - one cycle when a hold reaches LONG_CYCLES (no auto-repeat)
// DEBOUNCE_CYCLES and LONG_CYCLES must both be at least 2.
module button_event
    import button_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int unsigned LONG_CYCLES     = DEFAULT_LONG_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic pressed,
    output logic short_pulse,
    output logic long_pulse
);

    localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);

    localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

    logic              s;
    btn_state_t        state;
    logic [DB_W-1:0]   db_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    logic              long_flag;

    // Synchronizer resets to the released level so reset never looks like a press.
    sync2 #(
        .RESET_VALUE(1'b1)
    ) u_sync (
        .clk  (clk),
        .reset(reset),
        .d    (btn_n),
        .q    (s)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= StIdle;
            db_cnt      <= '0;
            hold_cnt    <= '0;
            long_flag   <= 1'b0;
            pressed     <= 1'b0;
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;
        end else begin
            short_pulse <= 1'b0;
            long_pulse  <= 1'b0;

            case (state)
                StIdle: begin
                    if (!s) begin
                        state     <= StDbPress;
                        db_cnt    <= DB_ONE;
                        hold_cnt  <= '0;
                        long_flag <= 1'b0;
                    end
                end

                StDbPress: begin
                    if (s) begin
                        state <= StIdle;
                    end else if (db_cnt == DB_LAST) begin
                        state   <= StPressed;
                        pressed <= 1'b1;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end

                StPressed: begin
                    if (s) begin
                        state  <= StDbRel;
                        db_cnt <= DB_ONE;
                    end else if (hold_cnt == HOLD_LAST) begin
                        state      <= StHeld;
                        long_pulse <= 1'b1;
                        long_flag  <= 1'b1;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_ONE;
                    end
                end

                StHeld: begin
                    if (s) begin
                        state  <= StDbRel;
                        db_cnt <= DB_ONE;
                    end
                end

                // hold_cnt is left untouched here so a release bounce only pauses the hold timer.
                StDbRel: begin
                    if (!s) begin
                        state <= long_flag ? StHeld : StPressed;
                    end else if (db_cnt == DB_LAST) begin
                        state       <= StIdle;
                        pressed     <= 1'b0;
                        short_pulse <= ~long_flag;
                    end else begin
                        db_cnt <= db_cnt + DB_ONE;
                    end
                end

                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/button_event.md
# button_event

Debounces one active-low push-button input and turns it into clean, single-cycle user events for the control FSM: `short_pulse` for a tap and `long_pulse` for a hold. It is the input-side counterpart of the buzzer driver. Button events feed the game/control logic, which in turn fires the buzzer trigger. It sits directly behind the FPGA button pins, one instance per button.

## Interface
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples required to accept a level change (20 ms at 50 MHz). Must be ≥2.
- `LONG_CYCLES`, default 50_000_000: cycles a press must be held to count as a long press (1 s at 50 MHz). Must be ≥2.
- `clk`, in, 1: system clock, 50 MHz.
- `reset`, in, 1: asynchronous, active-low.
- `btn_n`, in, 1: raw button, asynchronous to `clk`, low = pressed.
- `pressed`, out, 1: debounced button level, high while the press is accepted.
- `short_pulse`, out, 1: one-cycle pulse on release of a press that never reached `LONG_CYCLES`.
- `long_pulse`, out, 1: one-cycle pulse when the hold reaches `LONG_CYCLES`.

## Operation
- Input path: 2-flop synchronizer on `btn_n` produces `s`. Both flops reset to 1 (released).
- Counters:
  - `db_cnt` is sized with `$clog2(DEBOUNCE_CYCLES)`.
  - `hold_cnt` is sized with `$clog2(LONG_CYCLES)`.
  - `long_flag` is a register recording that a long press already fired.
- FSM states: `IDLE`, `DB_PRESS`, `PRESSED`, `HELD`, `DB_REL`.
- `IDLE`:
  - `s`=0 → `DB_PRESS`; `db_cnt`←1, `hold_cnt`←0, `long_flag`←0.
- `DB_PRESS`:
  - `s`=1 → `IDLE` (bounce rejected, no event).
  - `s`=0 and `db_cnt`==`DEBOUNCE_CYCLES`-1 → `PRESSED`; `pressed`←1.
  - Otherwise `db_cnt`++.
- `PRESSED`:
  - `s`=1 → `DB_REL`; `db_cnt`←1.
  - `s`=0 and `hold_cnt`==`LONG_CYCLES`-1 → `HELD`; `long_pulse`←1, `long_flag`←1.
  - Otherwise `hold_cnt`++.
- `HELD`:
  - `s`=1 → `DB_REL`; `db_cnt`←1.
  - No further long pulses while held (no auto-repeat).
- `DB_REL`:
  - `s`=0 → return to `HELD` if `long_flag`, else `PRESSED`. `hold_cnt` is frozen during `DB_REL` and resumes, not restarts.
  - `s`=1 and `db_cnt`==`DEBOUNCE_CYCLES`-1 → `IDLE`; `pressed`←0, `short_pulse`←~`long_flag`.
  - Otherwise `db_cnt`++.
- Pulse outputs are registered. Each is high for exactly one cycle and defaults to 0 on every other cycle.
- `short_pulse` and `long_pulse` are never high in the same cycle, and never both for one press.
- Reset (asynchronous, any time, including mid-press):
  - FSM goes to `IDLE`; all counters and `long_flag` clear to 0.
  - Outputs reset to `pressed`=0, `short_pulse`=0, `long_pulse`=0. A pulse in flight is dropped.
  - A button still held after reset release is re-debounced as a new press.

## Timing
- `btn_n` first sampled low at edge n (stable afterwards):
  - FSM sees `s`=0 at edge n+2.
  - `pressed` is high after edge n+1+`DEBOUNCE_CYCLES`.
- `long_pulse` is high during the cycle starting `LONG_CYCLES` edges after `pressed` rose, provided there was no release bounce. Each bounce cycle spent in `DB_REL` delays it by that many cycles.
- Release first sampled high at edge m (stable): `pressed` falls, and any `short_pulse` is high, after edge m+1+`DEBOUNCE_CYCLES`.
- Any glitch shorter than `DEBOUNCE_CYCLES` samples produces no change in `pressed` and no pulse.

## Structure
- Shared package (`button_pkg`):
  - FSM state typedef/encoding (3-bit).
  - Default cycle constants, derived from the project-wide `CLK_FREQ` = 50_000_000 so they stay consistent with the buzzer duration.
- One sub-module, `sync2`: a 2-flop synchronizer with parameterized reset value (1 here). It is reused by other pin inputs.
- Everything else is a single always block for the FSM/counters plus the registered outputs.

## Test plan
All directed scenarios use `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=20.
- **Clean tap:** `btn_n` low 10 cycles then high → `pressed` high 5 cycles after the first low sample. One `short_pulse` appears 5 cycles after the release sample. `long_pulse` never fires.
- **Bounce rejection:** `btn_n` toggles low/high every 2 cycles for 30 cycles, then stays high → `pressed`, `short_pulse` and `long_pulse` all stay 0.
- **Long hold:** `btn_n` low 40 cycles → `long_pulse` fires exactly once, 20 cycles after `pressed` rose. On release, `pressed` falls and no `short_pulse` is issued.
- **Release bounce:** press held 10 cycles, then 2-cycle high glitch, then low 15 more cycles → still in hold. `long_pulse` fires after 20 counted hold cycles (glitch cycles excluded). Only one `pressed` rising edge occurs.
- **Reset mid-press:** assert `reset` during `PRESSED`, then release it with `btn_n` still low → outputs 0 during reset. `pressed` re-asserts 5 cycles after the first low sample post-reset. No pulse is emitted at reset.
- **Back-to-back taps:** two clean 8-cycle taps separated by 6 high cycles → exactly two `short_pulse`s, each one cycle wide.
